// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed UART byte stream,
// assembles little-endian words, writes them to IMEM and gates CPU reset.
module imem_loader #(
  parameter int unsigned DEPTH_LOG2     = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter bit          HOLD_AT_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned      IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam int unsigned      WIDX_W    = DEPTH_LOG2 + 1;
  localparam logic [16:0]      MAX_LEN   = 17'(2 ** DEPTH_LOG2);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t state_next;

  logic [15:0]       len;
  logic [7:0]        acc;
  logic [1:0]        byte_idx;
  logic [WIDX_W-1:0] word_idx;
  logic [WIDX_W-1:0] word_next_idx;
  logic [23:0]       asm_word;
  logic [IDLE_W-1:0] idle_cnt;
  logic [15:0]       len_full;

  logic start;
  logic word_done;
  logic frame_ok;
  logic frame_bad;

  assign busy = (state == LEN_LO) || (state == LEN_HI) ||
                (state == DATA)   || (state == CHK);

  assign word_next_idx = word_idx + 1'b1;
  assign len_full      = {rx_data, len[7:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    word_done  = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_next = LEN_LO;
          start      = 1'b1;
        end
      end
      LEN_LO: begin
        if (rx_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (rx_valid) begin
          if ({1'b0, len_full} > MAX_LEN) begin
            state_next = ERR;
            frame_bad  = 1'b1;
          end else if (len_full == 16'd0) begin
            state_next = CHK;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid && (byte_idx == 2'd3)) begin
          word_done = 1'b1;
          if (16'(word_next_idx) == len) state_next = CHK;
        end
      end
      CHK: begin
        if (rx_valid) begin
          if (rx_data == acc) begin
            state_next = DONE;
            frame_ok   = 1'b1;
          end else begin
            state_next = ERR;
            frame_bad  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Idle timeout only fires on a byte-free cycle, so it never collides
    // with a byte-driven transition above.
    if (busy && !rx_valid && (idle_cnt == IDLE_LAST)) begin
      state_next = ERR;
      frame_bad  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cpu_hold <= HOLD_AT_RESET;
      done     <= 1'b0;
      err      <= 1'b0;
      len      <= '0;
      acc      <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      asm_word <= '0;
      idle_cnt <= '0;
    end else begin
      we <= 1'b0;

      if (busy && !rx_valid) idle_cnt <= idle_cnt + 1'b1;
      else                   idle_cnt <= '0;

      if (start) begin
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
        acc      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
      end

      if (rx_valid && (state == LEN_LO || state == LEN_HI || state == DATA))
        acc <= acc ^ rx_data;

      if (rx_valid && state == LEN_LO) len[7:0]  <= rx_data;
      if (rx_valid && state == LEN_HI) len[15:8] <= rx_data;

      if (rx_valid && state == DATA) begin
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          2'd0:    asm_word[7:0]   <= rx_data;
          2'd1:    asm_word[15:8]  <= rx_data;
          2'd2:    asm_word[23:16] <= rx_data;
          default: ;
        endcase
      end

      if (word_done) begin
        we       <= 1'b1;
        waddr    <= 32'({word_idx[DEPTH_LOG2-1:0], 2'b00});
        wdata    <= {rx_data, asm_word};
        word_idx <= word_next_idx;
      end

      if (frame_ok) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end

      if (frame_bad) err <= 1'b1;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. It accepts a framed byte stream from the UART receiver, assembles little-endian 32-bit instruction words, and issues single-cycle word writes into the instruction RAM that the core's fetch port reads. This lets a new program image replace the one fixed at elaboration by `$readmemh` without resynthesis. While a frame is in progress the block holds the CPU in reset, and it releases the CPU only after the frame's checksum verifies.

## Interface
- `DEPTH_LOG2`, default 8: log2 of the instruction memory depth in words (256 words).
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum number of idle clocks allowed between bytes inside a frame.
- `HOLD_AT_RESET`, default 1: reset value of `cpu_hold`.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `we`  out  1  instruction RAM write enable; one-cycle pulse.
- `waddr`  out  32  byte address of the write, equal to `{word_index, 2'b00}`.
- `wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  high means the core is held in reset.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  sticky; set when a frame completes with a good checksum.
- `err`  out  1  sticky; set on a bad length, bad checksum or timeout.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- Frame format: `SYNC_BYTE`, then `len[7:0]`, then `len[15:8]`, then `len` words of 4 bytes each (byte 0 = bits [7:0]), then a checksum byte.
  - The checksum is the XOR of every byte after the sync byte, up to but excluding the checksum byte itself.
- IDLE, DONE, ERR: receiving `rx_data == SYNC_BYTE` moves to LEN_LO. On that transition:
  - clear `done` and `err`;
  - set `cpu_hold` to 1;
  - clear the checksum accumulator, the word index and the byte index.
  - Any other byte is ignored.
- LEN_LO → LEN_HI → DATA: each transition consumes one byte into `len`.
  - On leaving LEN_HI: if `len > 2**DEPTH_LOG2`, go to ERR.
  - If `len == 0`, go straight to CHK.
- DATA: each byte shifts into the assembly register at position `byte_idx` (a 2-bit counter).
  - When byte 3 arrives, the next cycle drives `we=1`, `waddr={word_idx,2'b00}` and `wdata=` the assembled word.
  - `word_idx` increments after the write. When `word_idx` reaches `len`, go to CHK.
- CHK: compare the received byte with the accumulator.
  - Equal: go to DONE, set `done=1`, `cpu_hold=0`.
  - Not equal: go to ERR, set `err=1`; `cpu_hold` stays 1.
- Timeout: in LEN_LO, LEN_HI, DATA and CHK, an idle counter resets on every `rx_valid` and increments otherwise.
  - Reaching `TIMEOUT_CYCLES` goes to ERR and sets `err=1`.
- Words already written before an error are not rolled back. `cpu_hold` remains high, so the partial image is never executed.
- `busy` is 1 exactly in LEN_LO, LEN_HI, DATA and CHK.
- A `SYNC_BYTE` value received inside a frame is treated as data, not as a restart.

## Timing
- Reset (synchronous) forces:
  - state IDLE;
  - `we=0`, `waddr=0`, `wdata=0`;
  - `busy=0`, `done=0`, `err=0`;
  - `cpu_hold=HOLD_AT_RESET`;
  - all counters and the accumulator to 0.
- Reset mid-frame aborts the frame immediately. No `we` pulse occurs in the reset cycle.
- Write latency: `we` is asserted in the cycle after the clock edge that captures the 4th byte of a word. It is high for exactly one cycle.
- `done` and `cpu_hold` change in the cycle after the checksum byte is captured.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no byte loss.
- `waddr` and `wdata` hold their last values when `we=0`.
- `waddr` never exceeds `(2**DEPTH_LOG2 - 1)*4`.

## Test plan
- Reset, then send A5 02 00 13 05 50 00 B3 02 20 00 plus the correct checksum.
  - Expect `we` at 0x0 with 0x00500513 and at 0x4 with 0x002002B3, then `done=1`, `cpu_hold=0`.
- Send the same frame with the checksum byte inverted.
  - Expect both writes, then `err=1`, `done=0`, `cpu_hold=1`.
- Send A5 01 01 (len=257).
  - Expect ERR after the LEN_HI byte, no `we` pulses and `err=1`.
- Send A5 00 00 00 (len=0 with checksum 00).
  - Expect `done=1`, no writes.
- Send A5 01 00 13 05, then keep `rx_valid` low for `TIMEOUT_CYCLES` (bench parameter 16).
  - Expect `err=1` at cycle 16, no `we` pulse.
  - Then a full valid frame recovers to `done=1`.
- Assert `reset` in the middle of a word (after 2 of its 4 bytes).
  - Expect all outputs at their reset values and no write.
  - A following full frame loads correctly starting at `waddr=0`.
